// File: rtl/inst_fetch_unit_if.sv
// Bundles the CPU fetch handshake and the instruction-memory block-read bus.
// The fetch unit uses the slave view; the CPU/memory side uses the master view.
interface inst_fetch_unit_if #(
    parameter int WORD_SIZE  = 32,
    parameter int BLOCK_SIZE = 1024
);
    logic                  req_valid;
    logic [WORD_SIZE-1:0]  req_addr;
    logic                  req_ready;
    logic                  resp_valid;
    logic [WORD_SIZE-1:0]  resp_data;
    logic                  flush;
    logic [WORD_SIZE-1:0]  mem_addr;
    logic                  mem_readable;
    logic                  mem_writable;
    logic [BLOCK_SIZE-1:0] mem_write;
    logic [BLOCK_SIZE-1:0] mem_rdata;

    modport slave (
        input  req_valid, req_addr, flush, mem_rdata,
        output req_ready, resp_valid, resp_data,
               mem_addr, mem_readable, mem_writable, mem_write
    );

    modport master (
        output req_valid, req_addr, flush, mem_rdata,
        input  req_ready, resp_valid, resp_data,
               mem_addr, mem_readable, mem_writable, mem_write
    );
endinterface

// File: rtl/inst_fetch_unit.sv
// Instruction fetch front end: one-line block buffer in front of a fixed-latency
// block-read instruction memory, serving one word request at a time.
module inst_fetch_unit #(
    parameter int WORD_SIZE   = 32,
    parameter int BLOCK_SIZE  = 1024,
    parameter int OFFSET_BITS = 5,
    parameter int MEM_LATENCY = 2
) (
    input  logic               clk,
    input  logic               rst,
    inst_fetch_unit_if.slave   bus,
    output logic [15:0]        miss_count
);
    localparam int NWORDS = BLOCK_SIZE / WORD_SIZE;
    localparam int TAG_W  = WORD_SIZE - OFFSET_BITS;
    localparam int LAT_W  = 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_RESP
    } state_t;

    state_t                 state_q, state_d;
    logic                   ready_q, ready_d;
    logic                   resp_valid_q, resp_valid_d;
    logic [WORD_SIZE-1:0]   resp_data_q, resp_data_d;
    logic [WORD_SIZE-1:0]   mem_addr_q, mem_addr_d;
    logic                   mem_rd_q, mem_rd_d;
    logic [LAT_W-1:0]       lat_q, lat_d;
    logic [TAG_W-1:0]       tag_q, tag_d;
    logic [OFFSET_BITS-1:0] idx_q, idx_d;
    logic [TAG_W-1:0]       line_tag_q, line_tag_d;
    logic                   line_valid_q, line_valid_d;
    logic [BLOCK_SIZE-1:0]  line_q, line_d;
    logic [15:0]            miss_q, miss_d;
    logic                   flush_pend_q, flush_pend_d;

    logic [TAG_W-1:0]       req_tag;
    logic [OFFSET_BITS-1:0] req_idx;
    logic                   accept;
    logic                   hit;
    logic [WORD_SIZE-1:0]   line_words [NWORDS];

    assign req_tag = bus.req_addr[WORD_SIZE-1:OFFSET_BITS];
    assign req_idx = bus.req_addr[OFFSET_BITS-1:0];
    assign accept  = bus.req_valid && ready_q;
    // A flush in the accept cycle wins over the stored line, forcing a refill.
    assign hit     = line_valid_q && (req_tag == line_tag_q) && !bus.flush;

    for (genvar g = 0; g < NWORDS; g++) begin : g_words
        assign line_words[g] = line_q[g*WORD_SIZE +: WORD_SIZE];
    end

    always_comb begin
        state_d      = state_q;
        ready_d      = 1'b0;
        resp_valid_d = 1'b0;
        resp_data_d  = resp_data_q;
        mem_addr_d   = mem_addr_q;
        mem_rd_d     = mem_rd_q;
        lat_d        = lat_q;
        tag_d        = tag_q;
        idx_d        = idx_q;
        line_tag_d   = line_tag_q;
        line_valid_d = line_valid_q;
        line_d       = line_q;
        miss_d       = miss_q;
        flush_pend_d = flush_pend_q;

        case (state_q)
            S_IDLE: begin
                // Ready is registered, so it reopens one cycle after RESP.
                ready_d = !accept;
                if (bus.flush) begin
                    line_valid_d = 1'b0;
                end
                if (accept) begin
                    tag_d        = req_tag;
                    idx_d        = req_idx;
                    flush_pend_d = 1'b0;
                    if (hit) begin
                        state_d = S_RESP;
                    end else begin
                        state_d    = S_READ;
                        mem_addr_d = {req_tag, {OFFSET_BITS{1'b0}}};
                        mem_rd_d   = 1'b1;
                        lat_d      = LAT_W'(MEM_LATENCY - 1);
                    end
                end
            end

            S_READ: begin
                // A flush here cannot abort the fill; it is applied after the response.
                if (bus.flush) begin
                    flush_pend_d = 1'b1;
                end
                if (lat_q == '0) begin
                    line_d       = bus.mem_rdata;
                    line_tag_d   = tag_q;
                    line_valid_d = 1'b1;
                    mem_rd_d     = 1'b0;
                    if (miss_q != 16'hFFFF) begin
                        miss_d = miss_q + 16'd1;
                    end
                    state_d = S_RESP;
                end else begin
                    lat_d = lat_q - LAT_W'(1);
                end
            end

            S_RESP: begin
                resp_valid_d = 1'b1;
                resp_data_d  = line_words[idx_q];
                if (bus.flush || flush_pend_q) begin
                    line_valid_d = 1'b0;
                end
                flush_pend_d = 1'b0;
                state_d      = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            ready_q      <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            mem_addr_q   <= '0;
            mem_rd_q     <= 1'b0;
            lat_q        <= '0;
            line_tag_q   <= '0;
            line_valid_q <= 1'b0;
            miss_q       <= '0;
            flush_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ready_q      <= ready_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            mem_addr_q   <= mem_addr_d;
            mem_rd_q     <= mem_rd_d;
            lat_q        <= lat_d;
            line_tag_q   <= line_tag_d;
            line_valid_q <= line_valid_d;
            miss_q       <= miss_d;
            flush_pend_q <= flush_pend_d;
        end
    end

    // Request and line payload carry no reset; line_valid_q guards their use.
    always_ff @(posedge clk) begin
        tag_q  <= tag_d;
        idx_q  <= idx_d;
        line_q <= line_d;
    end

    assign bus.req_ready    = ready_q;
    assign bus.resp_valid   = resp_valid_q;
    assign bus.resp_data    = resp_data_q;
    assign bus.mem_addr     = mem_addr_q;
    assign bus.mem_readable = mem_rd_q;
    assign bus.mem_writable = 1'b0;
    assign bus.mem_write    = '0;
    assign miss_count       = miss_q;
endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit against a line-buffer model and a
// synthetic memory whose word at address a is {a[15:0], ~a[15:0]}.
module tb_inst_fetch_unit;
    localparam int MEM_LAT = 2;

    logic        clk;
    logic        rst;
    logic [15:0] miss_count;

    inst_fetch_unit_if #(.WORD_SIZE(32), .BLOCK_SIZE(1024)) bus ();

    inst_fetch_unit #(
        .WORD_SIZE(32), .BLOCK_SIZE(1024), .OFFSET_BITS(5), .MEM_LATENCY(MEM_LAT)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus), .miss_count(miss_count)
    );

    int          n_checks;
    int          n_fail;
    bit          mon_en;
    bit          rst_abort;
    logic [31:0] exp_blk;
    bit          m_valid;
    logic [26:0] m_tag;
    int          m_miss;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] memword(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    always_comb begin
        bus.mem_rdata = '0;
        for (int i = 0; i < 32; i++) begin
            bus.mem_rdata[i*32 +: 32] = memword(bus.mem_addr + 32'(i));
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic monitor();
        int   run;
        logic prev_rv;
        run = 0;
        prev_rv = 1'b0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                chk("mem_writable", 64'(bus.mem_writable), 64'd0);
                chk("mem_write", 64'(|bus.mem_write), 64'd0);
                if (bus.mem_readable) begin
                    chk("mem_addr", 64'(bus.mem_addr), 64'(exp_blk));
                    chk("ready_busy", 64'(bus.req_ready), 64'd0);
                    run++;
                end else if (run != 0) begin
                    if (!rst_abort) chk("readable_len", 64'(run), 64'(MEM_LAT));
                    run = 0;
                end
                if (bus.resp_valid) chk("resp_pulse", 64'(prev_rv), 64'd0);
                prev_rv = bus.resp_valid;
            end
        end
    endtask

    task automatic wait_ready(input string nm);
        bit rdy;
        rdy = 1'b0;
        for (int i = 0; i < 20 && !rdy; i++) begin
            @(negedge clk);
            rdy = bus.req_ready;
        end
        chk({nm, "_ready"}, 64'(rdy), 64'd1);
    endtask

    task automatic fetch(input string nm, input logic [31:0] addr, input bit exp_hit,
                         input bit fl_acc, input bit fl_read, output logic [31:0] data);
        bit mhit;
        bit got;
        bit rd_seen;
        int cyc;
        mhit = m_valid && (addr[31:5] == m_tag) && !fl_acc;
        chk({nm, "_model_hit"}, 64'(mhit), 64'(exp_hit));
        exp_blk = {addr[31:5], 5'b0};
        wait_ready(nm);
        bus.req_valid = 1'b1;
        bus.req_addr  = addr;
        bus.flush     = fl_acc;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.req_addr  = 32'hDEAD_BEEF;
        bus.flush     = 1'b0;
        got = 1'b0;
        rd_seen = 1'b0;
        cyc = 0;
        while (!got && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (bus.mem_readable) rd_seen = 1'b1;
            if (fl_read) bus.flush = (cyc == 1);
            got = bus.resp_valid;
        end
        bus.flush = 1'b0;
        data = bus.resp_data;
        chk({nm, "_latency"}, 64'(cyc), mhit ? 64'd2 : 64'(MEM_LAT + 2));
        chk({nm, "_data"}, 64'(bus.resp_data), 64'(memword(addr)));
        chk({nm, "_mem_read"}, 64'(rd_seen), 64'(!mhit));
        if (!mhit) begin
            m_valid = 1'b1;
            m_tag   = addr[31:5];
            m_miss++;
        end
        if (fl_read) m_valid = 1'b0;
        chk({nm, "_miss_count"}, 64'(miss_count), 64'(m_miss));
    endtask

    initial begin
        logic [31:0] d;
        logic [31:0] addrs [3];
        int          rc [3];
        int          acc;
        int          nresp;
        bit          quiet;

        n_checks = 0;
        n_fail = 0;
        mon_en = 1'b0;
        rst_abort = 1'b0;
        exp_blk = '0;
        m_valid = 1'b0;
        m_tag = '0;
        m_miss = 0;
        rst = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_addr = '0;
        bus.flush = 1'b0;
        fork
            monitor();
        join_none

        repeat (3) @(posedge clk);
        @(negedge clk);
        mon_en = 1'b1;
        chk("rst_ready", 64'(bus.req_ready), 64'd0);
        chk("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
        chk("rst_resp_data", 64'(bus.resp_data), 64'd0);
        chk("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
        chk("rst_readable", 64'(bus.mem_readable), 64'd0);
        chk("rst_miss_count", 64'(miss_count), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", 64'(bus.req_ready), 64'd1);

        fetch("miss129", 32'd129, 1'b0, 1'b0, 1'b0, d);
        chk("lit_data129", 64'(d), 64'h0081_FF7E);
        fetch("hit159", 32'd159, 1'b1, 1'b0, 1'b0, d);
        chk("lit_data159", 64'(d), 64'h009F_FF60);
        chk("lit_miss1", 64'(miss_count), 64'd1);
        fetch("miss160", 32'd160, 1'b0, 1'b0, 1'b0, d);
        fetch("remiss129", 32'd129, 1'b0, 1'b0, 1'b0, d);
        chk("lit_miss3", 64'(miss_count), 64'd3);

        // Flush while idle drops the line holding block 128.
        wait_ready("flush_idle");
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        m_valid = 1'b0;
        fetch("flushed129", 32'd129, 1'b0, 1'b0, 1'b0, d);
        fetch("flushread160", 32'd160, 1'b0, 1'b0, 1'b1, d);
        chk("lit_data160", 64'(d), 64'h00A0_FF5F);
        fetch("after_flush161", 32'd161, 1'b0, 1'b0, 1'b0, d);
        fetch("hit162", 32'd162, 1'b1, 1'b0, 1'b0, d);
        fetch("flushacc163", 32'd163, 1'b0, 1'b1, 1'b0, d);
        fetch("hit164", 32'd164, 1'b1, 1'b0, 1'b0, d);
        chk("lit_miss7", 64'(miss_count), 64'd7);

        fetch("allones", 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, d);
        chk("lit_data_allones", 64'(d), 64'hFFFF_0000);
        fetch("word0_top", 32'hFFFF_FFE0, 1'b1, 1'b0, 1'b0, d);

        // Back-to-back hits with req_valid held high.
        fetch("tp_fill", 32'd160, 1'b0, 1'b0, 1'b0, d);
        addrs[0] = 32'd160;
        addrs[1] = 32'd175;
        addrs[2] = 32'd191;
        rc[0] = 0;
        rc[1] = 0;
        rc[2] = 0;
        exp_blk = 32'd160;
        wait_ready("tp");
        bus.req_valid = 1'b1;
        bus.req_addr = addrs[0];
        acc = 0;
        nresp = 0;
        for (int c = 0; c < 40 && nresp < 3; c++) begin
            if (c > 0) @(negedge clk);
            chk("tp_ready", 64'(bus.req_ready), 64'((c % 3) == 0));
            if (bus.resp_valid) begin
                chk("tp_data", 64'(bus.resp_data), 64'(memword(addrs[nresp])));
                rc[nresp] = c;
                nresp++;
            end
            if (bus.req_valid && bus.req_ready) acc++;
            @(posedge clk);
            #1;
            if (acc >= 3) bus.req_valid = 1'b0;
            else bus.req_addr = addrs[acc];
        end
        bus.req_valid = 1'b0;
        chk("tp_nresp", 64'(nresp), 64'd3);
        chk("tp_gap1", 64'(rc[1] - rc[0]), 64'd3);
        chk("tp_gap2", 64'(rc[2] - rc[1]), 64'd3);
        chk("tp_miss_count", 64'(miss_count), 64'(m_miss));

        // Reset in the middle of a fill of block 256.
        exp_blk = 32'd256;
        wait_ready("rstread");
        bus.req_valid = 1'b1;
        bus.req_addr = 32'd256;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        chk("rstread_readable", 64'(bus.mem_readable), 64'd1);
        rst_abort = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        chk("rstread_readable_off", 64'(bus.mem_readable), 64'd0);
        chk("rstread_miss_count", 64'(miss_count), 64'd0);
        chk("rstread_ready_low", 64'(bus.req_ready), 64'd0);
        chk("rstread_no_resp", 64'(bus.resp_valid), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rstread_ready_high", 64'(bus.req_ready), 64'd1);
        quiet = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (bus.resp_valid) quiet = 1'b0;
            @(negedge clk);
        end
        chk("rstread_quiet", 64'(quiet), 64'd1);
        rst_abort = 1'b0;
        m_valid = 1'b0;
        m_miss = 0;
        fetch("after_rst256", 32'd256, 1'b0, 1'b0, 1'b0, d);
        chk("lit_miss_after_rst", 64'(miss_count), 64'd1);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
- Requester-side front end for the instruction memory block-read interface.
- Accepts one word-address fetch at a time from the CPU pipeline and keeps one block-sized line buffer.
- On a line-buffer miss, drives a block read to instruction memory, waits a fixed latency, captures the block, then returns the selected word.
- Sits between the CPU fetch stage and the instruction memory; it is the initiator for the memory's readable/writable/write/out interface.

Parameters:
- WORD_SIZE, 32, bits per instruction word and per address.
- BLOCK_SIZE, 1024, bits per memory block; BLOCK_SIZE/WORD_SIZE = 32 words per block.
- OFFSET_BITS, 5, log2(BLOCK_SIZE/WORD_SIZE); word-in-block index width.
- MEM_LATENCY, 2, cycles from the first cycle mem_readable is high to the cycle mem_rdata is sampled; legal range 1..15.

Ports:
- clk, input, 1, system clock; all state updates on the rising edge.
- rst, input, 1, synchronous active-high reset.
- req_valid, input, 1, CPU fetch request.
- req_addr, input, WORD_SIZE, word address of the requested instruction.
- req_ready, output, 1, unit can accept a request this cycle.
- resp_valid, output, 1, resp_data valid; one-cycle pulse.
- resp_data, output, WORD_SIZE, fetched instruction word.
- flush, input, 1, invalidate the line buffer.
- mem_addr, output, WORD_SIZE, block-aligned word address (low OFFSET_BITS = 0).
- mem_readable, output, 1, memory read enable.
- mem_writable, output, 1, memory write enable; constant 0.
- mem_write, output, BLOCK_SIZE, write data; constant 0.
- mem_rdata, input, BLOCK_SIZE, block returned by memory (memory out1).
- miss_count, output, 16, number of completed line fills; saturates at 16'hFFFF.

Behaviour:
- Reset values: req_ready=0 during rst and 1 the cycle after; resp_valid=0; resp_data=0; mem_addr=0; mem_readable=0; miss_count=0; line valid=0; FSM state=IDLE.
- Address split: tag=req_addr[WORD_SIZE-1:OFFSET_BITS]; idx=req_addr[OFFSET_BITS-1:0]. Word i of a block is bits [i*WORD_SIZE +: WORD_SIZE], with word 0 at the LSB.
- Request acceptance: a request is accepted when req_valid && req_ready. The unit latches addr and tag, and req_ready drops the next cycle. The CPU holds no obligation after acceptance.
- IDLE state, req_ready=1:
  - Accepted request with valid && tag==line_tag is a hit: go to RESP.
  - Any other accepted request is a miss: go to READ, set mem_addr={tag, OFFSET_BITS'b0}, set mem_readable=1, and load lat_cnt=MEM_LATENCY-1.
- READ state:
  - mem_readable and mem_addr are held constant.
  - lat_cnt decrements each cycle.
  - When lat_cnt==0, sample mem_rdata into the line buffer, set line_tag=tag and valid=1, increment miss_count, drop mem_readable, and go to RESP.
- RESP state:
  - resp_valid=1 for exactly one cycle.
  - resp_data = the line-buffer word at latched idx.
  - Then go to IDLE with req_ready=1.
- Latency, accept edge to resp_valid: hit = 2 cycles; miss = MEM_LATENCY+2 cycles.
- Throughput: at most one outstanding request; there is no pipelining.
- Flush:
  - In IDLE or RESP, flush clears valid on the next edge. A request accepted in the same cycle as flush is treated as a miss.
  - In READ, flush does not abort the fill; the fill completes, but valid is forced to 0 after RESP. The current response is still delivered.
- rst mid-READ: mem_readable drops on that edge and the fill is discarded; no resp_valid is produced; miss_count is cleared.
- Wrap-around: idx 31 selects bits [1023:992]; req_addr = all ones is legal and has tag = all ones.
- mem_writable and mem_write are never driven nonzero.

Test Plan:
- Reset, then req_addr=129 with MEM_LATENCY=2 -> mem_addr=128 with mem_readable high for 2 cycles; resp_valid 4 cycles after accept; resp_data = mem_rdata[63:32]; miss_count=1.
- Follow with req_addr=159 -> hit: resp_valid 2 cycles after accept; resp_data = mem_rdata[1023:992]; mem_readable stays 0; miss_count still 1.
- req_addr=160 -> miss: mem_addr=160; line replaced; then req_addr=129 -> miss again; miss_count=3.
- Assert flush in IDLE, then req_addr=160 -> miss; assert flush during READ -> response still delivered, and the next req_addr=161 is a miss.
- Assert rst during READ of addr 256 -> no resp_valid; mem_readable=0 next cycle; miss_count=0; req_ready=1 the following cycle.
- Hold req_valid high continuously over 3 hits -> resp_valid pulses every 3 cycles; req_ready low while busy; mem_writable=0 throughout.
